// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace streamer.
// No logic here; the FSM encoding and entry layout are used by the top and the FIFO.
// Entry layout order matters: it fixes the FIFO word format.
package wb_trace_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         PKT_BYTES = 10;

    typedef struct packed {
        logic [2:0]  seq;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] result;
    } trace_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/wb_trace_streamer_fifo.sv
// Synchronous FIFO holding captured trace entries, head visible combinationally.
// Latency: a push is visible at the head one edge later; level is registered.
// Backpressure: push while full is accepted only if a pop happens the same cycle.
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(trace_entry_t)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    // A pop frees the slot being written, so a full FIFO can still take a push.
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and level registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/wb_trace_streamer.sv
// Captures WB register writes and streams each as a 10-byte packet (A5, {seq,rd}, pc LE, result LE).
// Latency: event at edge E0 into an idle, empty streamer shows byte0 after edge E1.
// Backpressure: tx_ready stalls the byte stream; a full FIFO drops events and counts them.
module wb_trace_streamer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter bit CAPTURE_X0 = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic                   wb_reg_write,
    input  logic [4:0]             wb_rd,
    input  logic [31:0]            wb_result,
    input  logic [31:0]            wb_pc,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic [7:0]             drop_count,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int EW = $bits(trace_entry_t);

    ser_state_t    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [71:0]   shreg_q, shreg_d;
    logic [2:0]    seq_q, seq_d;
    logic [7:0]    drop_q, drop_d;
    logic          ovf_q, ovf_d;

    logic          qualify;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          drop;
    trace_entry_t  push_entry;
    trace_entry_t  head_entry;
    logic [EW-1:0] head_bits;
    logic [71:0]   head_load;

    assign qualify    = trace_en && wb_reg_write && ((wb_rd != 5'd0) || CAPTURE_X0);
    assign push_entry = '{seq: seq_q, rd: wb_rd, pc: wb_pc, result: wb_result};
    assign fifo_push  = qualify && (!fifo_full || fifo_pop);
    assign drop       = qualify && !fifo_push;
    assign head_entry = trace_entry_t'(head_bits);
    // Low byte goes out first after the sync byte, so pc and result land little-endian.
    assign head_load  = {head_entry.result, head_entry.pc, head_entry.seq, head_entry.rd};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .pop_dat  (head_bits),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Serializer: next state, byte index, shift register, pop request and stream outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = head_load;
                    idx_d    = 4'd0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = (idx_q == 4'd0) ? SYNC_BYTE : shreg_q[7:0];
                tx_last  = (idx_q == 4'(PKT_BYTES - 1));
                if (tx_ready) begin
                    if (tx_last) begin
                        // Chain straight into the next packet to avoid a bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shreg_d  = head_load;
                            idx_d    = 4'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        // The sync byte is a constant, so the shifter only moves after it.
                        if (idx_q != 4'd0) begin
                            shreg_d = {8'h00, shreg_q[71:8]};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequence, saturating drop counter and sticky overflow.
    always_comb begin
        seq_d  = seq_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (qualify) begin
            seq_d = seq_q + 3'd1;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // State registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            shreg_q <= '0;
            seq_q   <= 3'd0;
            drop_q  <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_wb_trace_streamer.sv
// Directed bench for wb_trace_streamer: capture, filtering, stalls, overflow, reset abort.
// Inputs are driven and outputs sampled on the falling edge.
// Expected packet bytes come from a hand-written packet format function.
module tb_wb_trace_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] wb_pc;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic [7:0]  drop_count;
    logic        overflow;
    logic [3:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_dat[$];
    logic       rx_last[$];
    int         hold_err;
    int         bubble;
    int         first_valid;
    bit         timed_out;
    bit         bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    wb_trace_streamer #(.DEPTH(8), .CAPTURE_X0(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .trace_en     (trace_en),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .wb_pc        (wb_pc),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input logic [2:0] s, input logic [4:0] r,
                                            input logic [31:0] p, input logic [31:0] d, input int i);
        case (i)
            0:       return 8'hA5;
            1:       return {s, r};
            2:       return p[7:0];
            3:       return p[15:8];
            4:       return p[23:16];
            5:       return p[31:24];
            6:       return d[7:0];
            7:       return d[15:8];
            8:       return d[23:16];
            default: return d[31:24];
        endcase
    endfunction

    task automatic drive_ev(input logic en, input logic we, input logic [4:0] rd,
                            input logic [31:0] pc, input logic [31:0] res);
        trace_en     = en;
        wb_reg_write = we;
        wb_rd        = rd;
        wb_pc        = pc;
        wb_result    = res;
    endtask

    task automatic clear_ev();
        wb_reg_write = 1'b0;
        wb_rd        = 5'd0;
    endtask

    // Called on a falling edge; returns on the falling edge after the last accepted byte.
    task automatic collect(input int nbytes, input bit bp);
        int         cyc = 0;
        bit         stalled = 1'b0;
        bit         started = 1'b0;
        logic [7:0] held = 8'h00;
        logic       held_last = 1'b0;
        rx_dat.delete();
        rx_last.delete();
        hold_err    = 0;
        bubble      = 0;
        first_valid = -1;
        timed_out   = 1'b0;
        while (rx_dat.size() < nbytes) begin
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            if (stalled && (!tx_valid || tx_data !== held || tx_last !== held_last)) hold_err++;
            if (started && !tx_valid) bubble++;
            if (tx_valid && !started) begin
                started     = 1'b1;
                first_valid = cyc;
            end
            tx_ready  = bp ? bp_pat[cyc % 4] : 1'b1;
            stalled   = tx_valid && !tx_ready;
            held      = tx_data;
            held_last = tx_last;
            if (tx_valid && tx_ready) begin
                rx_dat.push_back(tx_data);
                rx_last.push_back(tx_last);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        tx_ready = 1'b0;
        trace_en = 1'b1;
        clear_ev();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        total++; if (tx_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", tx_last); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", tx_data); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_single();
        logic [7:0] e;
        do_reset();
        tx_ready = 1'b1;
        drive_ev(1'b1, 1'b1, 5'd5, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        clear_ev();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", tx_valid); end
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        collect(10, 1'b0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL single_timeout: got %b want 0", timed_out); end
        total++; if (first_valid !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", first_valid); end
        for (int i = 0; i < 10 && i < rx_dat.size(); i++) begin
            e = exp_byte(3'd0, 5'd5, 32'h0000_0010, 32'hDEAD_BEEF, i);
            total++; if (rx_dat[i] !== e) begin bad++; $display("FAIL single_byte%0d: got %h want %h", i, rx_dat[i], e); end
            total++; if (rx_last[i] !== (i == 9)) begin bad++; $display("FAIL single_last%0d: got %b want %b", i, rx_last[i], (i == 9)); end
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_idle_after: got %b want 0", tx_valid); end
    endtask

    task automatic test_filter();
        do_reset();
        tx_ready = 1'b1;
        drive_ev(1'b1, 1'b1, 5'd0, 32'h1, 32'h1);
        @(negedge clk);
        drive_ev(1'b1, 1'b0, 5'd4, 32'h2, 32'h2);
        @(negedge clk);
        drive_ev(1'b0, 1'b1, 5'd4, 32'h3, 32'h3);
        @(negedge clk);
        clear_ev();
        trace_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL filter_level%0d: got %0d want 0", i, fifo_level); end
            total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL filter_valid%0d: got %b want 0", i, tx_valid); end
            @(negedge clk);
        end
        drive_ev(1'b1, 1'b1, 5'd7, 32'h0000_0020, 32'h0000_0011);
        @(negedge clk);
        clear_ev();
        collect(10, 1'b0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL filter_timeout: got %b want 0", timed_out); end
        if (rx_dat.size() == 10) begin
            total++; if (rx_dat[0] !== 8'hA5) begin bad++; $display("FAIL filter_sync: got %h want a5", rx_dat[0]); end
            total++; if (rx_dat[1] !== 8'h07) begin bad++; $display("FAIL filter_seq: got %h want 07", rx_dat[1]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] e;
        do_reset();
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_ev(1'b1, 1'b1, 5'(k + 1), 32'h0000_1100 + 32'(k), 32'hA0B0_C0D0 + 32'(k));
            @(negedge clk);
        end
        clear_ev();
        collect(30, 1'b1);
        total++; if (rx_dat.size() !== 30) begin bad++; $display("FAIL bp_count: got %0d want 30", rx_dat.size()); end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold: got %0d want 0", hold_err); end
        total++; if (bubble !== 0) begin bad++; $display("FAIL bp_bubble: got %0d want 0", bubble); end
        for (int i = 0; i < rx_dat.size(); i++) begin
            e = exp_byte(3'(i / 10), 5'(i / 10 + 1), 32'h0000_1100 + 32'(i / 10),
                         32'hA0B0_C0D0 + 32'(i / 10), i % 10);
            total++; if (rx_dat[i] !== e) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_dat[i], e); end
            total++; if (rx_last[i] !== ((i % 10) == 9)) begin bad++; $display("FAIL bp_last%0d: got %b want %b", i, rx_last[i], ((i % 10) == 9)); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_ev(1'b1, 1'b1, 5'(i + 1), 32'h0000_1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            @(negedge clk);
        end
        clear_ev();
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
        total++; if (drop_count !== 8'd3) begin bad++; $display("FAIL ovf_drop: got %0d want 3", drop_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", tx_valid); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL ovf_head: got %h want a5", tx_data); end
    endtask

    // Continues from test_overflow: FIFO full, serializer holding seq 0 at byte0.
    task automatic test_full_push_pop();
        logic [7:0]  e;
        logic [2:0]  s;
        logic [4:0]  r;
        logic [31:0] p;
        logic [31:0] d;
        tx_ready = 1'b1;
        repeat (9) @(negedge clk);
        total++; if (tx_last !== 1'b1) begin bad++; $display("FAIL fpp_at_last: got %b want 1", tx_last); end
        drive_ev(1'b1, 1'b1, 5'd20, 32'h0000_0100, 32'h0000_0055);
        @(negedge clk);
        clear_ev();
        total++; if (drop_count !== 8'd3) begin bad++; $display("FAIL fpp_drop: got %0d want 3", drop_count); end
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL fpp_level: got %0d want 8", fifo_level); end
        collect(90, 1'b0);
        total++; if (rx_dat.size() !== 90) begin bad++; $display("FAIL fpp_count: got %0d want 90", rx_dat.size()); end
        for (int i = 0; i < rx_dat.size(); i++) begin
            if (i < 80) begin
                s = 3'((i / 10) + 1);
                r = 5'((i / 10) + 2);
                p = 32'h0000_1000 + 32'(((i / 10) + 1) * 4);
                d = 32'hC0DE_0000 + 32'((i / 10) + 1);
            end else begin
                s = 3'd4;
                r = 5'd20;
                p = 32'h0000_0100;
                d = 32'h0000_0055;
            end
            e = exp_byte(s, r, p, d, i % 10);
            total++; if (rx_dat[i] !== e) begin bad++; $display("FAIL fpp_byte%0d: got %h want %h", i, rx_dat[i], e); end
        end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL fpp_drained: got %0d want 0", fifo_level); end
    endtask

    // Continues with drop_count=3 and overflow=1 so that reset clearing them is visible.
    task automatic test_reset_mid_packet();
        tx_ready = 1'b1;
        drive_ev(1'b1, 1'b1, 5'd9, 32'h0000_0040, 32'h0000_0077);
        @(negedge clk);
        clear_ev();
        collect(5, 1'b0);
        total++; if (rx_dat.size() !== 5) begin bad++; $display("FAIL rst_pre_count: got %0d want 5", rx_dat.size()); end
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", tx_valid); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
        total++; if (tx_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", tx_last); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", tx_data); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        reset = 1'b1;
        drive_ev(1'b1, 1'b1, 5'd3, 32'h0000_0080, 32'h0000_0099);
        @(negedge clk);
        clear_ev();
        collect(10, 1'b0);
        total++; if (rx_dat.size() !== 10) begin bad++; $display("FAIL rst_post_count: got %0d want 10", rx_dat.size()); end
        if (rx_dat.size() == 10) begin
            total++; if (rx_dat[0] !== 8'hA5) begin bad++; $display("FAIL rst_post_sync: got %h want a5", rx_dat[0]); end
            total++; if (rx_dat[1] !== 8'h03) begin bad++; $display("FAIL rst_post_seq: got %h want 03", rx_dat[1]); end
            total++; if (rx_last[9] !== 1'b1) begin bad++; $display("FAIL rst_post_last: got %b want 1", rx_last[9]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 270; i++) begin
            drive_ev(1'b1, 1'b1, 5'd1, 32'(i), 32'(i));
            @(negedge clk);
        end
        clear_ev();
        total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_drop: got %0d want 255", drop_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %b want 1", overflow); end
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL sat_level: got %0d want 8", fifo_level); end
    endtask

    initial begin
        reset        = 1'b0;
        trace_en     = 1'b0;
        wb_reg_write = 1'b0;
        wb_rd        = 5'd0;
        wb_result    = 32'd0;
        wb_pc        = 32'd0;
        tx_ready     = 1'b0;
        test_reset();
        test_single();
        test_filter();
        test_back_pressure();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_packet();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
